// File: rtl/decode.sv
// RV32I + Zicsr decode stage: combinational decode of the fetched word into a
// registered control bundle for execute, with exception tagging for bad words/pcs.
module decode (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic [31:0] next_pc_in,
  input  logic [31:0] instruction_in,
  input  logic        valid_in,
  input  logic        stall,
  input  logic        invalidate,
  output logic [4:0]  rs1_address,
  output logic [4:0]  rs2_address,
  output logic [31:0] pc_out,
  output logic [31:0] next_pc_out,
  output logic [4:0]  rs1_address_out,
  output logic [4:0]  rs2_address_out,
  output logic [4:0]  rd_address,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic [31:0] imm,
  output logic [2:0]  alu_function,
  output logic        alu_modifier,
  output logic [1:0]  alu_select_a,
  output logic        alu_select_b,
  output logic [2:0]  cmp_function,
  output logic        branch,
  output logic        jump,
  output logic        load,
  output logic        store,
  output logic        load_signed,
  output logic [1:0]  load_store_size,
  output logic [1:0]  writeback_select,
  output logic        csr_read,
  output logic        csr_write,
  output logic [1:0]  csr_op,
  output logic [11:0] csr_address,
  output logic        mret,
  output logic        wfi,
  output logic        exception,
  output logic [3:0]  ecause,
  output logic        valid_out
);

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [31:0] WORD_ECALL  = 32'h0000_0073;
  localparam logic [31:0] WORD_EBREAK = 32'h0010_0073;
  localparam logic [31:0] WORD_MRET   = 32'h3020_0073;
  localparam logic [31:0] WORD_WFI    = 32'h1050_0073;

  typedef struct packed {
    logic [4:0]  rd;
    logic        uses_rs1;
    logic        uses_rs2;
    logic [31:0] imm;
    logic [2:0]  alu_function;
    logic        alu_modifier;
    logic [1:0]  alu_select_a;
    logic        alu_select_b;
    logic [2:0]  cmp_function;
    logic        branch;
    logic        jump;
    logic        load;
    logic        store;
    logic        load_signed;
    logic [1:0]  load_store_size;
    logic [1:0]  writeback_select;
    logic        csr_read;
    logic        csr_write;
    logic [1:0]  csr_op;
    logic [11:0] csr_address;
    logic        mret;
    logic        wfi;
    logic        exception;
    logic [3:0]  ecause;
  } ctl_t;

  logic [31:0] w_instr;
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  logic        w_misaligned;
  logic        w_illegal;
  logic        w_ecall;
  logic        w_ebreak;
  logic        w_trap;
  ctl_t        w_ctl;

  ctl_t        r_ctl;
  logic [31:0] r_pc;
  logic [31:0] r_next_pc;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic        r_valid;

  assign w_instr      = instruction_in;
  assign w_opcode     = w_instr[6:0];
  assign w_funct3     = w_instr[14:12];
  assign w_funct7     = w_instr[31:25];
  assign w_rd         = w_instr[11:7];
  assign w_rs1        = w_instr[19:15];
  assign w_misaligned = (pc_in[1:0] != 2'b00);

  assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
  assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
  assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
  assign w_imm_u = {w_instr[31:12], 12'h000};
  assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};

  assign rs1_address = w_instr[19:15];
  assign rs2_address = w_instr[24:20];

  always_comb begin
    w_ctl                 = '0;
    w_illegal             = 1'b0;
    w_ecall               = 1'b0;
    w_ebreak              = 1'b0;
    w_trap                = 1'b0;
    w_ctl.cmp_function    = w_funct3;
    w_ctl.load_store_size = w_funct3[1:0];
    w_ctl.load_signed     = ~w_funct3[2];
    w_ctl.csr_address     = w_instr[31:20];
    case (w_opcode)
      OPC_LUI: begin
        w_ctl.rd           = w_rd;
        w_ctl.imm          = w_imm_u;
        w_ctl.alu_select_a = 2'd2;
        w_ctl.alu_select_b = 1'b1;
      end
      OPC_AUIPC: begin
        w_ctl.rd           = w_rd;
        w_ctl.imm          = w_imm_u;
        w_ctl.alu_select_a = 2'd1;
        w_ctl.alu_select_b = 1'b1;
      end
      OPC_JAL: begin
        w_ctl.rd               = w_rd;
        w_ctl.imm              = w_imm_j;
        w_ctl.alu_select_a     = 2'd1;
        w_ctl.alu_select_b     = 1'b1;
        w_ctl.jump             = 1'b1;
        w_ctl.writeback_select = 2'd1;
      end
      OPC_JALR: begin
        w_illegal              = (w_funct3 != 3'd0);
        w_ctl.rd               = w_rd;
        w_ctl.imm              = w_imm_i;
        w_ctl.uses_rs1         = 1'b1;
        w_ctl.alu_select_b     = 1'b1;
        w_ctl.jump             = 1'b1;
        w_ctl.writeback_select = 2'd1;
      end
      OPC_BRANCH: begin
        w_illegal      = (w_funct3[2:1] == 2'b01);
        w_ctl.imm      = w_imm_b;
        w_ctl.uses_rs1 = 1'b1;
        w_ctl.uses_rs2 = 1'b1;
        w_ctl.branch   = 1'b1;
      end
      OPC_LOAD: begin
        w_illegal              = (w_funct3 == 3'd3) || (w_funct3[2:1] == 2'b11);
        w_ctl.rd               = w_rd;
        w_ctl.imm              = w_imm_i;
        w_ctl.uses_rs1         = 1'b1;
        w_ctl.alu_select_b     = 1'b1;
        w_ctl.load             = 1'b1;
        w_ctl.writeback_select = 2'd2;
      end
      OPC_STORE: begin
        w_illegal          = (w_funct3 > 3'd2);
        w_ctl.imm          = w_imm_s;
        w_ctl.uses_rs1     = 1'b1;
        w_ctl.uses_rs2     = 1'b1;
        w_ctl.alu_select_b = 1'b1;
        w_ctl.store        = 1'b1;
      end
      OPC_OP_IMM: begin
        // Shift-immediates reuse funct7 as the arithmetic/logical selector.
        if (w_funct3 == 3'd1)
          w_illegal = (w_funct7 != 7'h00);
        else if (w_funct3 == 3'd5)
          w_illegal = (w_funct7 != 7'h00) && (w_funct7 != 7'h20);
        w_ctl.rd           = w_rd;
        w_ctl.imm          = w_imm_i;
        w_ctl.uses_rs1     = 1'b1;
        w_ctl.alu_select_b = 1'b1;
        w_ctl.alu_function = w_funct3;
        w_ctl.alu_modifier = (w_funct3 == 3'd5) && w_instr[30];
      end
      OPC_OP: begin
        w_illegal = !((w_funct7 == 7'h00) ||
                      ((w_funct7 == 7'h20) && ((w_funct3 == 3'd0) || (w_funct3 == 3'd5))));
        w_ctl.rd           = w_rd;
        w_ctl.uses_rs1     = 1'b1;
        w_ctl.uses_rs2     = 1'b1;
        w_ctl.alu_function = w_funct3;
        w_ctl.alu_modifier = w_instr[30];
      end
      OPC_MISC_MEM: begin
        w_illegal = (w_funct3[2:1] != 2'b00);
      end
      OPC_SYSTEM: begin
        if (w_funct3 == 3'd0) begin
          case (w_instr)
            WORD_ECALL:  w_ecall   = 1'b1;
            WORD_EBREAK: w_ebreak  = 1'b1;
            WORD_MRET:   w_ctl.mret = 1'b1;
            WORD_WFI:    w_ctl.wfi  = 1'b1;
            default:     w_illegal = 1'b1;
          endcase
        end else if (w_funct3 == 3'd4) begin
          w_illegal = 1'b1;
        end else begin
          w_ctl.rd               = w_rd;
          w_ctl.uses_rs1         = ~w_funct3[2];
          w_ctl.imm              = {27'd0, w_rs1};
          w_ctl.writeback_select = 2'd3;
          w_ctl.csr_op           = w_funct3[1:0];
          w_ctl.csr_read         = !((w_funct3[1:0] == 2'b01) && (w_rd == 5'd0));
          w_ctl.csr_write        = !(w_funct3[1] && (w_rs1 == 5'd0));
        end
      end
      default: w_illegal = 1'b1;
    endcase

    w_trap = w_misaligned | w_illegal | w_ecall | w_ebreak;
    if (w_trap) begin
      w_ctl.exception = 1'b1;
      if (w_misaligned)   w_ctl.ecause = 4'd0;
      else if (w_illegal) w_ctl.ecause = 4'd2;
      else if (w_ecall)   w_ctl.ecause = 4'd11;
      else                w_ctl.ecause = 4'd3;
      w_ctl.rd        = 5'd0;
      w_ctl.uses_rs1  = 1'b0;
      w_ctl.uses_rs2  = 1'b0;
      w_ctl.load      = 1'b0;
      w_ctl.store     = 1'b0;
      w_ctl.jump      = 1'b0;
      w_ctl.branch    = 1'b0;
      w_ctl.csr_read  = 1'b0;
      w_ctl.csr_write = 1'b0;
      w_ctl.mret      = 1'b0;
      w_ctl.wfi       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ctl     <= '0;
      r_pc      <= '0;
      r_next_pc <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_valid   <= 1'b0;
    end else if (!stall) begin
      r_ctl     <= w_ctl;
      r_pc      <= pc_in;
      r_next_pc <= next_pc_in;
      r_rs1     <= w_instr[19:15];
      r_rs2     <= w_instr[24:20];
      r_valid   <= valid_in & ~invalidate;
    end
  end

  assign pc_out           = r_pc;
  assign next_pc_out      = r_next_pc;
  assign rs1_address_out  = r_rs1;
  assign rs2_address_out  = r_rs2;
  assign valid_out        = r_valid;
  assign rd_address       = r_ctl.rd;
  assign uses_rs1         = r_ctl.uses_rs1;
  assign uses_rs2         = r_ctl.uses_rs2;
  assign imm              = r_ctl.imm;
  assign alu_function     = r_ctl.alu_function;
  assign alu_modifier     = r_ctl.alu_modifier;
  assign alu_select_a     = r_ctl.alu_select_a;
  assign alu_select_b     = r_ctl.alu_select_b;
  assign cmp_function     = r_ctl.cmp_function;
  assign branch           = r_ctl.branch;
  assign jump             = r_ctl.jump;
  assign load             = r_ctl.load;
  assign store            = r_ctl.store;
  assign load_signed      = r_ctl.load_signed;
  assign load_store_size  = r_ctl.load_store_size;
  assign writeback_select = r_ctl.writeback_select;
  assign csr_read         = r_ctl.csr_read;
  assign csr_write        = r_ctl.csr_write;
  assign csr_op           = r_ctl.csr_op;
  assign csr_address      = r_ctl.csr_address;
  assign mret             = r_ctl.mret;
  assign wfi              = r_ctl.wfi;
  assign exception        = r_ctl.exception;
  assign ecause           = r_ctl.ecause;

endmodule

// File: tb/tb_decode.sv
// Scoreboarded bench for decode: directed test-plan words, stall/invalidate/reset
// scenarios and randomized words checked against an instruction-level model.
module tb_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in, next_pc_in, instruction_in;
  logic        valid_in, stall, invalidate;
  logic [4:0]  rs1_address, rs2_address;
  logic [31:0] pc_out, next_pc_out;
  logic [4:0]  rs1_address_out, rs2_address_out, rd_address;
  logic        uses_rs1, uses_rs2;
  logic [31:0] imm;
  logic [2:0]  alu_function;
  logic        alu_modifier;
  logic [1:0]  alu_select_a;
  logic        alu_select_b;
  logic [2:0]  cmp_function;
  logic        branch, jump, load, store, load_signed;
  logic [1:0]  load_store_size, writeback_select;
  logic        csr_read, csr_write;
  logic [1:0]  csr_op;
  logic [11:0] csr_address;
  logic        mret, wfi, exception;
  logic [3:0]  ecause;
  logic        valid_out;

  decode dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .next_pc_in(next_pc_in),
    .instruction_in(instruction_in), .valid_in(valid_in), .stall(stall),
    .invalidate(invalidate), .rs1_address(rs1_address), .rs2_address(rs2_address),
    .pc_out(pc_out), .next_pc_out(next_pc_out), .rs1_address_out(rs1_address_out),
    .rs2_address_out(rs2_address_out), .rd_address(rd_address), .uses_rs1(uses_rs1),
    .uses_rs2(uses_rs2), .imm(imm), .alu_function(alu_function),
    .alu_modifier(alu_modifier), .alu_select_a(alu_select_a),
    .alu_select_b(alu_select_b), .cmp_function(cmp_function), .branch(branch),
    .jump(jump), .load(load), .store(store), .load_signed(load_signed),
    .load_store_size(load_store_size), .writeback_select(writeback_select),
    .csr_read(csr_read), .csr_write(csr_write), .csr_op(csr_op),
    .csr_address(csr_address), .mret(mret), .wfi(wfi), .exception(exception),
    .ecause(ecause), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] pc, npc, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2;
    logic [2:0]  af;
    logic        am;
    logic [1:0]  sa;
    logic        sb;
    logic [2:0]  cf;
    logic        br, jp, ld, st, ls;
    logic [1:0]  lss, wb;
    logic        cr, cw;
    logic [1:0]  cop;
    logic [11:0] ca;
    logic        mr, wf, ex;
    logic [3:0]  ec;
    logic        care_sel, care_imm, care_ls, care_csr;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   checks = 0;
  int   failures = 0;
  logic mon_en = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] pc, input logic [31:0] npc,
                                 input logic [31:0] ins, input logic vin, input logic inv);
    exp_t e = '{default: '0};
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    logic [6:0] f7 = ins[31:25];
    logic [4:0] rdf = ins[11:7];
    logic [4:0] rsf = ins[19:15];
    logic legal = 1'b1, ecall = 1'b0, ebreak = 1'b0, misal;
    logic [31:0] i_imm = 32'($signed(ins[31:20]));
    logic [31:0] s_imm = 32'($signed({ins[31:25], ins[11:7]}));
    logic [31:0] b_imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    logic [31:0] u_imm = {ins[31:12], 12'h000};
    logic [31:0] j_imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    e.valid = vin & !inv;
    e.pc = pc; e.npc = npc; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.cf = f3;
    e.care_sel = 1'b1;
    case (op)
      7'h37: begin e.rd = rdf; e.imm = u_imm; e.care_imm = 1; e.sa = 2'd2; e.sb = 1; end
      7'h17: begin e.rd = rdf; e.imm = u_imm; e.care_imm = 1; e.sa = 2'd1; e.sb = 1; end
      7'h6F: begin e.rd = rdf; e.imm = j_imm; e.care_imm = 1; e.sa = 2'd1; e.sb = 1;
                   e.jp = 1; e.wb = 2'd1; end
      7'h67: begin legal = (f3 == 3'd0); e.rd = rdf; e.imm = i_imm; e.care_imm = 1;
                   e.u1 = 1; e.sb = 1; e.jp = 1; e.wb = 2'd1; end
      7'h63: begin legal = !(f3 inside {3'd2, 3'd3}); e.imm = b_imm; e.care_imm = 1;
                   e.u1 = 1; e.u2 = 1; e.br = 1; e.care_sel = 0; end
      7'h03: begin legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}); e.rd = rdf;
                   e.imm = i_imm; e.care_imm = 1; e.u1 = 1; e.sb = 1; e.ld = 1; e.wb = 2'd2;
                   e.care_ls = 1; e.lss = 2'(f3 % 4); e.ls = (f3 < 3'd4); end
      7'h23: begin legal = (f3 <= 3'd2); e.imm = s_imm; e.care_imm = 1; e.u1 = 1; e.u2 = 1;
                   e.sb = 1; e.st = 1; e.care_ls = 1; e.lss = 2'(f3 % 4); e.ls = 1; end
      7'h13: begin
        if (f3 == 3'd1) legal = (f7 == 7'h00);
        if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
        e.rd = rdf; e.imm = i_imm; e.care_imm = 1; e.u1 = 1; e.sb = 1; e.af = f3;
        e.am = (f3 == 3'd5) ? ins[30] : 1'b0;
      end
      7'h33: begin
        legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        e.rd = rdf; e.u1 = 1; e.u2 = 1; e.af = f3; e.am = ins[30];
      end
      7'h0F: begin legal = (f3 <= 3'd1); e.care_sel = 0; end
      7'h73: begin
        e.care_sel = 0;
        if (f3 == 3'd0) begin
          if (ins == 32'h00000073) ecall = 1;
          else if (ins == 32'h00100073) ebreak = 1;
          else if (ins == 32'h30200073) e.mr = 1;
          else if (ins == 32'h10500073) e.wf = 1;
          else legal = 0;
        end else if (f3 == 3'd4) begin
          legal = 0;
        end else begin
          e.rd = rdf; e.wb = 2'd3; e.care_csr = 1; e.cop = 2'(f3 % 4); e.ca = ins[31:20];
          e.u1 = (f3 < 3'd4);
          if (f3 >= 3'd5) begin e.care_imm = 1; e.imm = {27'd0, rsf}; end
          e.cr = !((f3 == 3'd1 || f3 == 3'd5) && rdf == 5'd0);
          e.cw = !((f3 inside {3'd2, 3'd3, 3'd6, 3'd7}) && rsf == 5'd0);
        end
      end
      default: legal = 0;
    endcase
    misal = (pc % 4) != 0;
    if (misal || !legal || ecall || ebreak) begin
      e.ex = 1;
      e.ec = misal ? 4'd0 : (!legal ? 4'd2 : (ecall ? 4'd11 : 4'd3));
      e.rd = 0; e.ld = 0; e.st = 0; e.jp = 0; e.br = 0; e.cr = 0; e.cw = 0; e.mr = 0; e.wf = 0;
    end
    return e;
  endfunction

  task automatic check_out(input exp_t e);
    chk("valid_out", 32'(valid_out), 32'(e.valid));
    if (e.valid) begin
      chk("pc_out", pc_out, e.pc);
      chk("next_pc_out", next_pc_out, e.npc);
      chk("rs_addr_out", 32'({rs1_address_out, rs2_address_out}), 32'({e.rs1, e.rs2}));
      chk("exception", 32'(exception), 32'(e.ex));
      chk("rd_address", 32'(rd_address), 32'(e.rd));
      chk("side_effects", 32'({load, store, jump, branch, csr_read, csr_write, mret, wfi}),
          32'({e.ld, e.st, e.jp, e.br, e.cr, e.cw, e.mr, e.wf}));
      if (e.ex) chk("ecause", 32'(ecause), 32'(e.ec));
      else begin
        chk("uses_rs", 32'({uses_rs1, uses_rs2}), 32'({e.u1, e.u2}));
        chk("alu_fn_mod", 32'({alu_function, alu_modifier}), 32'({e.af, e.am}));
        chk("cmp_function", 32'(cmp_function), 32'(e.cf));
        chk("writeback_select", 32'(writeback_select), 32'(e.wb));
        if (e.care_sel) chk("alu_select", 32'({alu_select_a, alu_select_b}), 32'({e.sa, e.sb}));
        if (e.care_imm) chk("imm", imm, e.imm);
        if (e.care_ls) chk("ls_size_signed", 32'({load_store_size, load_signed}), 32'({e.lss, e.ls}));
        if (e.care_csr) chk("csr_op_addr", 32'({csr_op, csr_address}), 32'({e.cop, e.ca}));
      end
    end
  endtask

  // Monitor: one expectation consumed per unstalled edge; stalled edges must hold the last one.
  always @(posedge clk) begin
    exp_t e;
    if (mon_en && reset) begin
      if (stall) begin
        @(negedge clk);
        check_out(last_exp);
      end else if (exp_q.size() == 0) begin
        chk("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        last_exp = e;
        @(negedge clk);
        check_out(e);
      end
    end
  end

  task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic vin,
                      input logic st, input logic inv);
    logic [31:0] npc = $urandom();
    instruction_in = ins; pc_in = pc; next_pc_in = npc;
    valid_in = vin; stall = st; invalidate = inv;
    if (!st) exp_q.push_back(model(pc, npc, ins, vin, inv));
    #1;
    chk("rs1_address", 32'(rs1_address), 32'(ins[19:15]));
    chk("rs2_address", 32'(rs2_address), 32'(ins[24:20]));
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    chk(name, 32'(|{pc_out, next_pc_out, rs1_address_out, rs2_address_out, rd_address,
                   uses_rs1, uses_rs2, imm, alu_function, alu_modifier, alu_select_a,
                   alu_select_b, cmp_function, branch, jump, load, store, load_signed,
                   load_store_size, writeback_select, csr_read, csr_write, csr_op,
                   csr_address, mret, wfi, exception, ecause, valid_out}), 32'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom();
    logic [6:0]  ops [0:10];
    logic [31:0] specials [0:3];
    int k = $urandom_range(0, 15);
    int r;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    specials = '{32'h00000073, 32'h00100073, 32'h30200073, 32'h10500073};
    if (k < 11) begin
      w[6:0] = ops[k];
      r = $urandom_range(0, 3);
      if (ops[k] == 7'h33 || ops[k] == 7'h13) begin
        if (r < 2) w[31:25] = 7'h00;
        else if (r == 2) w[31:25] = 7'h20;
      end
      if (ops[k] == 7'h73) begin
        if (r == 0) w[19:15] = 5'd0;
        if (r == 1) w[11:7] = 5'd0;
      end
    end else if (k == 11) begin
      w = specials[$urandom_range(0, 3)];
    end
    return w;
  endfunction

  localparam logic [31:0] ADDI = 32'hFFD08293;
  exp_t zero_exp;

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ins, pc;
    zero_exp = '{default: '0};
    last_exp = zero_exp;
    reset = 1'b0; pc_in = 0; next_pc_in = 0; instruction_in = ADDI;
    valid_in = 1'b1; stall = 1'b1; invalidate = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset_state");
    @(negedge clk); #2 reset = 1'b1;

    step(ADDI, 32'h100, 1, 0, 0);
    chk("addi_valid", 32'(valid_out), 32'd1);
    chk("addi_rd", 32'(rd_address), 32'd5);
    chk("addi_rs1_out", 32'(rs1_address_out), 32'd1);
    chk("addi_imm", imm, 32'hFFFFFFFD);
    chk("addi_sel_b_wb", 32'({alu_select_b, alu_function, writeback_select}), 32'h20);
    step(32'h0021A423, 32'h104, 1, 0, 0);
    chk("sw_fields", 32'({store, load_store_size, rd_address, uses_rs2}), 32'b1_10_00000_1);
    chk("sw_imm", imm, 32'd8);
    step(32'h001000EF, 32'h108, 1, 0, 0);
    chk("jal_fields", 32'({jump, alu_select_a, writeback_select}), 32'b1_01_01);
    chk("jal_imm", imm, 32'h00000800);
    step(32'h00000000, 32'h10C, 1, 0, 0);
    chk("illegal0", 32'({exception, ecause, rd_address}), 32'({1'b1, 4'd2, 5'd0}));
    step(32'hFFFFFFFF, 32'h110, 1, 0, 0);
    chk("illegal1", 32'({exception, ecause, rd_address}), 32'({1'b1, 4'd2, 5'd0}));
    step(32'h00000073, 32'h114, 1, 0, 0);
    chk("ecall", 32'({exception, ecause}), 32'({1'b1, 4'd11}));
    step(32'h00100073, 32'h118, 1, 0, 0);
    chk("ebreak", 32'({exception, ecause}), 32'({1'b1, 4'd3}));
    step(ADDI, 32'h80000002, 1, 0, 0);
    chk("misaligned", 32'({exception, ecause}), 32'({1'b1, 4'd0}));
    step(32'h30002073, 32'h11C, 1, 0, 0);
    chk("csrrs_x0", 32'({csr_read, csr_write}), 32'b10);
    step(32'h3052D073, 32'h120, 1, 0, 0);
    chk("csrrwi", 32'({csr_read, uses_rs1, csr_address}), 32'({2'b00, 12'h305}));
    chk("csrrwi_imm", imm, 32'd5);
    step(32'h30200073, 32'h124, 1, 0, 0);
    step(32'h10500073, 32'h128, 1, 0, 0);
    step(32'h0000000F, 32'h12C, 1, 0, 0);

    // Stall hold while the input word keeps changing.
    step(ADDI, 32'h200, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(rand_instr(), $urandom(), 1, 1, i == 1);
    chk("stall_hold", 32'({valid_out, rd_address, pc_out[15:0]}), 32'({1'b1, 5'd5, 16'h0200}));
    step(ADDI, 32'h204, 1, 0, 1);
    chk("invalidate", 32'(valid_out), 32'd0);
    step(ADDI, 32'h208, 1, 0, 0);
    step(32'h0021A423, 32'h20C, 1, 1, 1);
    chk("stall_over_invalidate", 32'(valid_out), 32'd1);
    step(32'h0021A423, 32'h20C, 1, 0, 0);
    chk("leave_stall", 32'({store, pc_out[15:0]}), 32'({1'b1, 16'h020C}));

    // Asynchronous reset between edges.
    step(ADDI, 32'h300, 1, 0, 0);
    @(negedge clk); #2 reset = 1'b0;
    exp_q.delete();
    last_exp = zero_exp;
    #1 check_all_zero("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk); #2 reset = 1'b1;
    step(ADDI, 32'h400, 1, 0, 0);
    chk("after_reset", 32'({valid_out, rd_address}), 32'({1'b1, 5'd5}));

    for (int n = 0; n < 500; n++) begin
      ins = rand_instr();
      pc = $urandom();
      if ($urandom_range(0, 19) != 0) pc[1:0] = 2'b00;
      step(ins, pc, $urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 6) == 0);
    end

    step(ADDI, 32'h500, 0, 0, 0);
    mon_en = 1'b0;
    @(negedge clk); #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
